// File: rtl/calendar_pkg.sv
// calendar_pkg: month numbering, month lengths and day width shared by the calendar chain.
package calendar_pkg;
    localparam int DAY_W         = 5;
    localparam int NUMS_OF_MONTH = 12;
    localparam logic [3:0] JAN = 4'd1;
    localparam logic [3:0] FEB = 4'd2;
    localparam logic [3:0] MAR = 4'd3;
    localparam logic [3:0] APR = 4'd4;
    localparam logic [3:0] MAY = 4'd5;
    localparam logic [3:0] JUN = 4'd6;
    localparam logic [3:0] JUL = 4'd7;
    localparam logic [3:0] AUG = 4'd8;
    localparam logic [3:0] SEP = 4'd9;
    localparam logic [3:0] OCT = 4'd10;
    localparam logic [3:0] NOV = 4'd11;
    localparam logic [3:0] DEC = 4'd12;
    localparam logic [DAY_W-1:0] DAYS_28 = 5'd28;
    localparam logic [DAY_W-1:0] DAYS_29 = 5'd29;
    localparam logic [DAY_W-1:0] DAYS_30 = 5'd30;
    localparam logic [DAY_W-1:0] DAYS_31 = 5'd31;
endpackage

// File: rtl/days_in_month_calc.sv
// days_in_month_calc: Gregorian leap-year test and month-length decode.
// Out-of-range months decode as 31 days so a bad month never shortens the count.
module days_in_month_calc
    import calendar_pkg::*;
#(
    parameter int YEAR_W = 14
) (
    input  logic [3:0]        month,
    input  logic [YEAR_W-1:0] year,
    output logic [DAY_W-1:0]  days_in_month,
    output logic              is_leap
);
    logic div4, div100, div400;

    assign div4    = (year % YEAR_W'(4))   == '0;
    assign div100  = (year % YEAR_W'(100)) == '0;
    assign div400  = (year % YEAR_W'(400)) == '0;
    assign is_leap = div4 && (!div100 || div400);

    always_comb begin
        days_in_month = DAYS_31;
        case (month)
            FEB:               days_in_month = is_leap ? DAYS_29 : DAYS_28;
            APR, JUN, SEP, NOV: days_in_month = DAYS_30;
            default:           days_in_month = DAYS_31;
        endcase
    end
endmodule

// File: rtl/day_counter.sv
// day_counter: day-of-month register advanced by the hour carry or set-mode strobes,
// with clamping when a month/year edit shortens the current month.
module day_counter
    import calendar_pkg::*;
#(
    parameter int YEAR_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              dec,
    input  logic              ctrl_set,
    input  logic              carry_in_hour,
    input  logic [3:0]        month,
    input  logic [YEAR_W-1:0] year,
    output logic [DAY_W-1:0]  day_count,
    output logic [DAY_W-1:0]  days_in_month,
    output logic              carry_out
);
    logic [DAY_W-1:0] day_q, day_d;
    logic             at_end, is_leap;

    days_in_month_calc #(.YEAR_W(YEAR_W)) u_calc (
        .month         (month),
        .year          (year),
        .days_in_month (days_in_month),
        .is_leap       (is_leap)
    );

    assign at_end    = day_q >= days_in_month;
    assign carry_out = !ctrl_set && carry_in_hour && at_end;
    assign day_count = day_q;

    always_comb begin
        day_d = day_q;
        if (ctrl_set && inc)
            day_d = at_end ? DAY_W'(1) : day_q + DAY_W'(1);
        else if (ctrl_set && dec)
            day_d = (day_q <= DAY_W'(1)) ? days_in_month : day_q - DAY_W'(1);
        else if (!ctrl_set && carry_in_hour)
            day_d = at_end ? DAY_W'(1) : day_q + DAY_W'(1);
        else if (day_q > days_in_month)
            day_d = days_in_month;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) day_q <= DAY_W'(1);
        else        day_q <= day_d;
endmodule
